// File: rtl/mmul_host_if.sv
// Enable/done link between the host-side initiator and the matrix-multiply core.
// The operand and result buses pack element (i,j) at bits [(i*N+j)*ELEM_W +: ELEM_W].
interface mmul_host_if #(
    parameter int ELEM_W = 8,
    parameter int N      = 3
);
    localparam int BUS_W = N * N * ELEM_W;

    logic             mmul_enable;
    logic [BUS_W-1:0] mmul_mat_a;
    logic [BUS_W-1:0] mmul_mat_b;
    logic [BUS_W-1:0] mmul_result;
    logic             mmul_done;

    modport master (
        output mmul_enable,
        output mmul_mat_a,
        output mmul_mat_b,
        input  mmul_result,
        input  mmul_done
    );

    modport slave (
        input  mmul_enable,
        input  mmul_mat_a,
        input  mmul_mat_b,
        output mmul_result,
        output mmul_done
    );
endinterface

// File: rtl/mmul_host.sv
// Byte-stream front end for the mmul core: loads A then B, raises enable until done,
// then streams the latched result back out, with a sticky timeout abort.
module mmul_host #(
    parameter int ELEM_W  = 8,
    parameter int N       = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ELEM_W-1:0] in_data,
    mmul_host_if.master       mmul,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ELEM_W-1:0] out_data,
    output logic              busy,
    output logic              timeout_err
);
    localparam int NN    = N * N;
    localparam int BUS_W = NN * ELEM_W;
    localparam int CNT_W = $clog2(2 * NN + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(2 * NN - 1);
    localparam logic [CNT_W-1:0] LAST_OUT = CNT_W'(NN - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_LOAD     = 2'd0,
        S_REQ      = 2'd1,
        S_WAIT_LOW = 2'd2,
        S_SEND     = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [BUS_W-1:0]  mat_a_q, mat_a_d;
    logic [BUS_W-1:0]  mat_b_q, mat_b_d;
    logic [BUS_W-1:0]  res_q, res_d;
    logic              enable_q, enable_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [ELEM_W-1:0] out_data_q, out_data_d;
    logic              busy_q, busy_d;
    logic              timeout_err_q, timeout_err_d;

    function automatic logic [ELEM_W-1:0] elem_at(input logic [BUS_W-1:0] bus,
                                                  input logic [CNT_W-1:0] idx);
        logic [ELEM_W-1:0] sel;
        sel = '0;
        for (int k = 0; k < NN; k++) begin
            sel = (idx == CNT_W'(k)) ? bus[k*ELEM_W +: ELEM_W] : sel;
        end
        return sel;
    endfunction

    // Next-state and next-output computation for the load/request/drain/send sequence.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        timer_d       = timer_q;
        mat_a_d       = mat_a_q;
        mat_b_d       = mat_b_q;
        res_d         = res_q;
        enable_d      = enable_q;
        in_ready_d    = in_ready_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            S_LOAD: begin
                if (in_valid && in_ready_q) begin
                    // Count 0..NN-1 addresses A, NN..2*NN-1 addresses B.
                    for (int k = 0; k < NN; k++) begin
                        mat_a_d[k*ELEM_W +: ELEM_W] = (count_q == CNT_W'(k))
                            ? in_data : mat_a_q[k*ELEM_W +: ELEM_W];
                        mat_b_d[k*ELEM_W +: ELEM_W] = (count_q == CNT_W'(NN + k))
                            ? in_data : mat_b_q[k*ELEM_W +: ELEM_W];
                    end
                    if (count_q == LAST_IN) begin
                        state_d    = S_REQ;
                        count_d    = '0;
                        timer_d    = '0;
                        in_ready_d = 1'b0;
                        enable_d   = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end else begin
                    count_d = count_q;
                end
            end
            S_REQ: begin
                if (mmul.mmul_done) begin
                    res_d    = mmul.mmul_result;
                    enable_d = 1'b0;
                    state_d  = S_WAIT_LOW;
                end else if (timer_q == TMR_LAST) begin
                    // Zeroed result still gets streamed so the host stays frame-aligned.
                    res_d         = '0;
                    timeout_err_d = 1'b1;
                    enable_d      = 1'b0;
                    state_d       = S_WAIT_LOW;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_WAIT_LOW: begin
                if (!mmul.mmul_done) begin
                    state_d     = S_SEND;
                    count_d     = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = elem_at(res_q, '0);
                end else begin
                    state_d = S_WAIT_LOW;
                end
            end
            S_SEND: begin
                if (out_valid_q && out_ready) begin
                    if (count_q == LAST_OUT) begin
                        state_d     = S_LOAD;
                        count_d     = '0;
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                    end else begin
                        count_d    = count_q + CNT_W'(1);
                        out_data_d = elem_at(res_q, count_q + CNT_W'(1));
                    end
                end else begin
                    count_d = count_q;
                end
            end
            default: begin
                state_d     = S_LOAD;
                count_d     = '0;
                enable_d    = 1'b0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase

        busy_d = !((state_d == S_LOAD) && (count_d == '0));
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_LOAD;
            count_q       <= '0;
            timer_q       <= '0;
            mat_a_q       <= '0;
            mat_b_q       <= '0;
            res_q         <= '0;
            enable_q      <= 1'b0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            timer_q       <= timer_d;
            mat_a_q       <= mat_a_d;
            mat_b_q       <= mat_b_d;
            res_q         <= res_d;
            enable_q      <= enable_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign in_ready         = in_ready_q;
    assign mmul.mmul_enable = enable_q;
    assign mmul.mmul_mat_a  = mat_a_q;
    assign mmul.mmul_mat_b  = mat_b_q;
    assign out_valid        = out_valid_q;
    assign out_data         = out_data_q;
    assign busy             = busy_q;
    assign timeout_err      = timeout_err_q;
endmodule

// File: tb/tb_mmul_host.sv
// Directed bench for mmul_host with a stub core (done 7 cycles after enable, result = A+B
// per element) and a queue scoreboard of expected output bytes.
module tb_mmul_host;
    localparam int ELEM_W  = 8;
    localparam int N       = 3;
    localparam int NN      = N * N;
    localparam int BUS_W   = NN * ELEM_W;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [ELEM_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ELEM_W-1:0] out_data;
    logic              busy;
    logic              timeout_err;

    mmul_host_if #(.ELEM_W(ELEM_W), .N(N)) mif ();

    mmul_host #(.ELEM_W(ELEM_W), .N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .mmul       (mif),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Stub core: mode 0 normal, 1 never done, 2 done lingers 3 cycles after enable drops.
    int         stub_mode;
    logic [3:0] stub_cnt;
    logic [3:0] hold_cnt;
    always @(posedge clk) begin
        if (reset) begin
            stub_cnt      <= 4'd0;
            hold_cnt      <= 4'd0;
            mif.mmul_done <= 1'b0;
        end else if (mif.mmul_enable) begin
            hold_cnt <= 4'd0;
            if (stub_mode != 1 && !mif.mmul_done) begin
                stub_cnt <= stub_cnt + 4'd1;
                if (stub_cnt == 4'd6) mif.mmul_done <= 1'b1;
            end
        end else begin
            stub_cnt <= 4'd0;
            if (mif.mmul_done && stub_mode == 2 && hold_cnt != 4'd2) begin
                hold_cnt <= hold_cnt + 4'd1;
            end else begin
                hold_cnt      <= 4'd0;
                mif.mmul_done <= 1'b0;
            end
        end
    end

    always_comb begin
        mif.mmul_result = '0;
        for (int k = 0; k < NN; k++)
            mif.mmul_result[k*ELEM_W +: ELEM_W] =
                mif.mmul_mat_a[k*ELEM_W +: ELEM_W] + mif.mmul_mat_b[k*ELEM_W +: ELEM_W];
    end

    int   cyc = 0;
    int   en_fall_cyc = 0;
    int   en_hi_cnt = 0;
    logic prev_en = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        prev_en <= mif.mmul_enable;
        if (prev_en === 1'b1 && mif.mmul_enable === 1'b0) en_fall_cyc <= cyc;
        if (mif.mmul_enable === 1'b1) en_hi_cnt <= en_hi_cnt + 1;
    end

    int                checks = 0;
    int                errors = 0;
    logic [ELEM_W-1:0] exp_q[$];
    int                en_hi_base;
    int                first_diff;
    logic [ELEM_W-1:0] fa[NN];
    logic [ELEM_W-1:0] fb[NN];

    task automatic check(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_enable"}, mif.mmul_enable, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_mat_a"}, mif.mmul_mat_a, 0);
        check({tag, "_mat_b"}, mif.mmul_mat_b, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Sends fa then fb, pushes the expected result bytes and checks the launch of REQ.
    task automatic send_frame(input int gap_max, input bit zero_result);
        logic [BUS_W-1:0]  exp_a;
        logic [BUS_W-1:0]  exp_b;
        logic [ELEM_W-1:0] s;
        int                n;
        for (int i = 0; i < 2 * NN; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = (i < NN) ? fa[i] : fb[i - NN];
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (in_ready !== 1'b1 && n < 100);
            if (n >= 100) begin
                check("in_ready_wait", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        en_hi_base = en_hi_cnt;
        for (int k = 0; k < NN; k++) begin
            exp_a[k*ELEM_W +: ELEM_W] = fa[k];
            exp_b[k*ELEM_W +: ELEM_W] = fb[k];
            s = fa[k] + fb[k];
            exp_q.push_back(zero_result ? 8'd0 : s);
        end
        check("enable_after_load", mif.mmul_enable, 1);
        check("in_ready_after_load", in_ready, 0);
        check("mat_a", mif.mmul_mat_a, exp_a);
        check("mat_b", mif.mmul_mat_b, exp_b);
    endtask

    // Drains one result frame, comparing each byte against the scoreboard.
    task automatic recv_frame(input bit stall);
        int                n;
        logic [ELEM_W-1:0] d0;
        logic [ELEM_W-1:0] e;
        if (stall) begin
            in_valid = 1'b1;
            in_data  = 8'hEE;
        end
        for (int k = 0; k < NN; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (stall && out_valid !== 1'b1) check("in_ready_outside_load", in_ready, 0);
            end while (out_valid !== 1'b1 && n < 300);
            if (n >= 300) begin
                check("out_valid_wait", 0, 1);
                in_valid = 1'b0;
                return;
            end
            if (k == 0) first_diff = cyc - en_fall_cyc;
            if (stall) begin
                d0 = out_data;
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    check("out_stable", {out_valid, out_data}, {1'b1, d0});
                    check("in_ready_in_send", in_ready, 0);
                end
            end
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", out_data, e);
            end
            if (k == NN - 1) in_valid = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
        check("idle_busy", busy, 0);
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;
        stub_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b0;

        // 1: bytes 1..18 back to back
        for (int k = 0; k < NN; k++) begin
            fa[k] = 8'(k + 1);
            fb[k] = 8'(k + 10);
        end
        send_frame(0, 1'b0);
        check("busy_in_req", busy, 1);
        recv_frame(1'b0);
        check("t1_enable_cycles", en_hi_cnt - en_hi_base, 8);
        check("t1_done_to_valid", first_diff, 2);

        // 2: same data with input gaps and output backpressure
        send_frame(3, 1'b0);
        recv_frame(1'b1);

        // 3: per-element wrap in the core passes through unchanged
        for (int k = 0; k < NN; k++) begin
            fa[k] = 8'd200;
            fb[k] = 8'd100;
        end
        send_frame(1, 1'b0);
        recv_frame(1'b0);

        // 5: lingering done delays SEND and is captured only once
        stub_mode = 2;
        for (int k = 0; k < NN; k++) begin
            fa[k] = 8'($urandom_range(0, 255));
            fb[k] = 8'($urandom_range(0, 255));
        end
        send_frame(0, 1'b0);
        recv_frame(1'b1);
        check("t5_done_to_valid", first_diff, 4);
        check("t5_enable_cycles", en_hi_cnt - en_hi_base, 8);
        repeat (6) @(posedge clk);
        #1;
        check("t5_no_second_req", mif.mmul_enable, 0);
        check("t5_no_second_out", out_valid, 0);

        // 4: core never answers -> timeout with nine zero bytes
        stub_mode = 1;
        send_frame(0, 1'b1);
        recv_frame(1'b0);
        check("t4_enable_cycles", en_hi_cnt - en_hi_base, TIMEOUT);
        check("t4_timeout_err", timeout_err, 1);
        stub_mode = 0;

        // 6: reset during REQ, then during SEND, then a clean frame
        for (int k = 0; k < NN; k++) begin
            fa[k] = 8'(3 * k + 5);
            fb[k] = 8'(7 * k + 1);
        end
        send_frame(0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("reset_in_req");
        reset = 1'b0;
        exp_q.delete();

        send_frame(0, 1'b0);
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (out_valid !== 1'b1 && n < 300);
            check("t6_reach_send", out_valid, 1);
        end
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("reset_in_send");
        reset = 1'b0;
        exp_q.delete();

        send_frame(2, 1'b0);
        recv_frame(1'b1);
        check("final_scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
